// File: rtl/tail_light_decoder.sv
// rtl/tail_light_decoder.sv - tail-light sequence decoder with saturating event counters
//
// Watches a 6-bit lamp pattern and recognises three-step left, right and
// hazard sequences, each closed by an all-off sample. It also flags protocol
// violations.
//   clk       : system clock, rising edge
//   reset     : synchronous active-high reset
//   y         : lamp pattern, y[5:3] left lamps, y[2:0] right lamps
//   clear     : synchronous active-high counter clear
//   left_det  : one-cycle pulse, left sequence completed
//   right_det : one-cycle pulse, right sequence completed
//   haz_det   : one-cycle pulse, hazard sequence completed
//   err       : one-cycle pulse, protocol violation
//   busy      : high while a sequence is in progress
//   *_cnt     : saturating event counters, CNT_W bits each
module tail_light_decoder #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [5:0]       y,
   input  logic             clear,
   output logic             left_det,
   output logic             right_det,
   output logic             haz_det,
   output logic             err,
   output logic             busy,
   output logic [CNT_W-1:0] left_cnt,
   output logic [CNT_W-1:0] right_cnt,
   output logic [CNT_W-1:0] haz_cnt,
   output logic [CNT_W-1:0] err_cnt
);

   typedef enum logic [3:0] {
      S_IDLE, S_SL1, S_SL2, S_SL3, S_SR1, S_SR2, S_SR3,
      S_SE1, S_SE2, S_SE3, S_RESYNC
   } state_t;

   localparam logic [5:0] P_OFF = 6'b000_000;
   localparam logic [5:0] P_L1  = 6'b001_000;
   localparam logic [5:0] P_L2  = 6'b011_000;
   localparam logic [5:0] P_L3  = 6'b111_000;
   localparam logic [5:0] P_R1  = 6'b000_100;
   localparam logic [5:0] P_R2  = 6'b000_110;
   localparam logic [5:0] P_R3  = 6'b000_111;
   localparam logic [5:0] P_E1  = 6'b001_100;
   localparam logic [5:0] P_E2  = 6'b011_110;
   localparam logic [5:0] P_E3  = 6'b111_111;

   localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);

   state_t           r_state;
   logic             r_left_det, r_right_det, r_haz_det, r_err, r_busy;
   logic [CNT_W-1:0] r_left_cnt, r_right_cnt, r_haz_cnt, r_err_cnt;

   state_t w_next;
   logic   w_left, w_right, w_haz, w_err, w_busy;

   // Next-state decode. Every mid-sequence state accepts exactly one pattern;
   // anything else is a violation that parks the FSM in RESYNC.
   always_comb begin
      w_next  = r_state;
      w_left  = 1'b0;
      w_right = 1'b0;
      w_haz   = 1'b0;
      w_err   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (y == P_OFF)     w_next = S_IDLE;
            else if (y == P_L1) w_next = S_SL1;
            else if (y == P_R1) w_next = S_SR1;
            else if (y == P_E1) w_next = S_SE1;
            else begin
               w_next = S_RESYNC;
               w_err  = 1'b1;
            end
         end
         S_SL1: if (y == P_L2) w_next = S_SL2; else begin w_next = S_RESYNC; w_err = 1'b1; end
         S_SL2: if (y == P_L3) w_next = S_SL3; else begin w_next = S_RESYNC; w_err = 1'b1; end
         S_SR1: if (y == P_R2) w_next = S_SR2; else begin w_next = S_RESYNC; w_err = 1'b1; end
         S_SR2: if (y == P_R3) w_next = S_SR3; else begin w_next = S_RESYNC; w_err = 1'b1; end
         S_SE1: if (y == P_E2) w_next = S_SE2; else begin w_next = S_RESYNC; w_err = 1'b1; end
         S_SE2: if (y == P_E3) w_next = S_SE3; else begin w_next = S_RESYNC; w_err = 1'b1; end
         S_SL3: begin
            if (y == P_OFF) begin w_next = S_IDLE; w_left = 1'b1; end
            else begin w_next = S_RESYNC; w_err = 1'b1; end
         end
         S_SR3: begin
            if (y == P_OFF) begin w_next = S_IDLE; w_right = 1'b1; end
            else begin w_next = S_RESYNC; w_err = 1'b1; end
         end
         S_SE3: begin
            if (y == P_OFF) begin w_next = S_IDLE; w_haz = 1'b1; end
            else begin w_next = S_RESYNC; w_err = 1'b1; end
         end
         // Silent until the lamps go dark, so one glitch costs one err.
         S_RESYNC: if (y == P_OFF) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
      // busy is registered from the next state so it lines up with the state.
      w_busy = (w_next != S_IDLE) && (w_next != S_RESYNC);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_left_det  <= 1'b0;
         r_right_det <= 1'b0;
         r_haz_det   <= 1'b0;
         r_err       <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_state     <= w_next;
         r_left_det  <= w_left;
         r_right_det <= w_right;
         r_haz_det   <= w_haz;
         r_err       <= w_err;
         r_busy      <= w_busy;
      end
   end

   // Counters advance on the same edge that raises the pulse, so a count
   // is visible together with its pulse; clear beats that increment.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         r_left_cnt  <= '0;
         r_right_cnt <= '0;
         r_haz_cnt   <= '0;
         r_err_cnt   <= '0;
      end else begin
         if (w_left  && (r_left_cnt  != '1)) r_left_cnt  <= r_left_cnt  + C_ONE;
         if (w_right && (r_right_cnt != '1)) r_right_cnt <= r_right_cnt + C_ONE;
         if (w_haz   && (r_haz_cnt   != '1)) r_haz_cnt   <= r_haz_cnt   + C_ONE;
         if (w_err   && (r_err_cnt   != '1)) r_err_cnt   <= r_err_cnt   + C_ONE;
      end
   end

   assign left_det  = r_left_det;
   assign right_det = r_right_det;
   assign haz_det   = r_haz_det;
   assign err       = r_err;
   assign busy      = r_busy;
   assign left_cnt  = r_left_cnt;
   assign right_cnt = r_right_cnt;
   assign haz_cnt   = r_haz_cnt;
   assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_tail_light_decoder.sv
// tb/tb_tail_light_decoder.sv - self-checking bench for tail_light_decoder
module tb_tail_light_decoder;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       clear = 1'b0;
   logic [5:0] y = 6'b000_000;

   logic       left_det, right_det, haz_det, err, busy;
   logic [7:0] left_cnt, right_cnt, haz_cnt, err_cnt;

   logic       s_left_det, s_right_det, s_haz_det, s_err, s_busy;
   logic [1:0] s_left_cnt, s_right_cnt, s_haz_cnt, s_err_cnt;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   tail_light_decoder #(.CNT_W(8)) dut (
      .clk(clk), .reset(reset), .y(y), .clear(clear),
      .left_det(left_det), .right_det(right_det), .haz_det(haz_det),
      .err(err), .busy(busy),
      .left_cnt(left_cnt), .right_cnt(right_cnt), .haz_cnt(haz_cnt), .err_cnt(err_cnt)
   );

   tail_light_decoder #(.CNT_W(2)) dut_sat (
      .clk(clk), .reset(reset), .y(y), .clear(clear),
      .left_det(s_left_det), .right_det(s_right_det), .haz_det(s_haz_det),
      .err(s_err), .busy(s_busy),
      .left_cnt(s_left_cnt), .right_cnt(s_right_cnt), .haz_cnt(s_haz_cnt), .err_cnt(s_err_cnt)
   );

   // flags = {left_det, right_det, haz_det, err, busy} after the edge
   typedef struct {
      logic       rst;
      logic       clr;
      logic [5:0] yv;
      logic [4:0] flags;
      logic [7:0] lc, rc, hc, ec;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic rst, input logic clr, input logic [5:0] yv,
                      input logic [4:0] flags, input logic [7:0] lc, input logic [7:0] rc,
                      input logic [7:0] hc, input logic [7:0] ec);
      vec_t v;
      v.rst = rst; v.clr = clr; v.yv = yv; v.flags = flags;
      v.lc = lc; v.rc = rc; v.hc = hc; v.ec = ec;
      tbl.push_back(v);
   endtask

   task automatic step(input logic rst, input logic clr, input logic [5:0] yv);
      reset = rst;
      clear = clr;
      y     = yv;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d required %0d", name, act, req);
      end
   endtask

   initial begin
      // reset
      add(1, 0, 6'b000_000, 5'b00000, 0, 0, 0, 0);
      // left sequence, busy for three cycles
      add(0, 0, 6'b001_000, 5'b00001, 0, 0, 0, 0);
      add(0, 0, 6'b011_000, 5'b00001, 0, 0, 0, 0);
      add(0, 0, 6'b111_000, 5'b00001, 0, 0, 0, 0);
      add(0, 0, 6'b000_000, 5'b10000, 1, 0, 0, 0);
      add(0, 0, 6'b000_000, 5'b00000, 1, 0, 0, 0);
      // hazard then right, back to back
      add(0, 0, 6'b001_100, 5'b00001, 1, 0, 0, 0);
      add(0, 0, 6'b011_110, 5'b00001, 1, 0, 0, 0);
      add(0, 0, 6'b111_111, 5'b00001, 1, 0, 0, 0);
      add(0, 0, 6'b000_000, 5'b00100, 1, 0, 1, 0);
      add(0, 0, 6'b000_100, 5'b00001, 1, 0, 1, 0);
      add(0, 0, 6'b000_110, 5'b00001, 1, 0, 1, 0);
      add(0, 0, 6'b000_111, 5'b00001, 1, 0, 1, 0);
      add(0, 0, 6'b000_000, 5'b01000, 1, 1, 1, 0);
      // broken left: single err, RESYNC until dark
      add(0, 0, 6'b001_000, 5'b00001, 1, 1, 1, 0);
      add(0, 0, 6'b000_110, 5'b00010, 1, 1, 1, 1);
      add(0, 0, 6'b000_110, 5'b00000, 1, 1, 1, 1);
      add(0, 0, 6'b000_000, 5'b00000, 1, 1, 1, 1);
      add(0, 0, 6'b000_000, 5'b00000, 1, 1, 1, 1);
      // illegal pattern from idle, held, then a valid right
      add(0, 0, 6'b010_010, 5'b00010, 1, 1, 1, 2);
      add(0, 0, 6'b010_010, 5'b00000, 1, 1, 1, 2);
      add(0, 0, 6'b000_000, 5'b00000, 1, 1, 1, 2);
      add(0, 0, 6'b000_100, 5'b00001, 1, 1, 1, 2);
      add(0, 0, 6'b000_110, 5'b00001, 1, 1, 1, 2);
      add(0, 0, 6'b000_111, 5'b00001, 1, 1, 1, 2);
      add(0, 0, 6'b000_000, 5'b01000, 1, 2, 1, 2);
      // SL3 must close with all-off
      add(0, 0, 6'b001_000, 5'b00001, 1, 2, 1, 2);
      add(0, 0, 6'b011_000, 5'b00001, 1, 2, 1, 2);
      add(0, 0, 6'b111_000, 5'b00001, 1, 2, 1, 2);
      add(0, 0, 6'b111_000, 5'b00010, 1, 2, 1, 3);
      add(0, 0, 6'b000_000, 5'b00000, 1, 2, 1, 3);
      // reset after E2 abandons silently; reset beats clear
      add(0, 0, 6'b001_100, 5'b00001, 1, 2, 1, 3);
      add(0, 0, 6'b011_110, 5'b00001, 1, 2, 1, 3);
      add(1, 1, 6'b111_111, 5'b00000, 0, 0, 0, 0);
      add(0, 0, 6'b000_000, 5'b00000, 0, 0, 0, 0);
      add(0, 0, 6'b000_000, 5'b00000, 0, 0, 0, 0);

      foreach (tbl[i]) begin
         step(tbl[i].rst, tbl[i].clr, tbl[i].yv);
         checks++;
         if ({left_det, right_det, haz_det, err, busy} != tbl[i].flags ||
             left_cnt != tbl[i].lc || right_cnt != tbl[i].rc ||
             haz_cnt != tbl[i].hc || err_cnt != tbl[i].ec) begin
            errors++;
            $display("FAIL vec%0d: got flags=%b cnt=%0d/%0d/%0d/%0d required flags=%b cnt=%0d/%0d/%0d/%0d",
                     i, {left_det, right_det, haz_det, err, busy},
                     left_cnt, right_cnt, haz_cnt, err_cnt,
                     tbl[i].flags, tbl[i].lc, tbl[i].rc, tbl[i].hc, tbl[i].ec);
         end
      end

      // Saturation on the 2-bit instance, clear on the fifth completion.
      step(1, 0, 6'b000_000);
      for (int n = 1; n <= 5; n++) begin
         step(0, 0, 6'b001_000);
         step(0, 0, 6'b011_000);
         step(0, 0, 6'b111_000);
         step(0, (n == 5), 6'b000_000);
         chk($sformatf("sat_det%0d", n), int'(s_left_det), 1);
         chk($sformatf("sat_cnt%0d", n), int'(s_left_cnt), (n == 5) ? 0 : ((n > 3) ? 3 : n));
         chk($sformatf("wide_cnt%0d", n), int'(left_cnt), (n == 5) ? 0 : n);
      end
      step(0, 0, 6'b000_000);
      chk("sat_cnt_after_clear", int'(s_left_cnt), 0);
      chk("det_after_clear", int'(s_left_det), 0);

      // Clear does not disturb an in-flight sequence.
      step(0, 0, 6'b000_100);
      step(0, 1, 6'b000_110);
      chk("clear_busy", int'(busy), 1);
      step(0, 0, 6'b000_111);
      step(0, 0, 6'b000_000);
      chk("clear_right_det", int'(right_det), 1);
      chk("clear_right_cnt", int'(right_cnt), 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
